// File: rtl/text_scroller_pkg.sv
// Shared constants, state encoding and index helper for the ASCII text scroller.
package text_scroller_pkg;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [31:0] BLANK_WORD  = 32'h20202020;

  typedef enum logic {
    ST_EDIT   = 1'b0,
    ST_SCROLL = 1'b1
  } state_t;

  // Single-subtraction modulo: callers guarantee idx < 2*modulus.
  function automatic logic [15:0] wrap_index(input logic [15:0] idx, input logic [15:0] modulus);
    if (idx >= modulus) begin
      wrap_index = idx - modulus;
    end else begin
      wrap_index = idx;
    end
  endfunction

endpackage

// File: rtl/text_scroller_if.sv
// Write/control/display bundle between a message source and the text scroller.
interface text_scroller_if #(
  parameter int DEPTH = 16
) ();
  localparam int LW = $clog2(DEPTH + 1);

  logic          clear;
  logic          wr_en;
  logic [7:0]    wr_char;
  logic          wr_ready;
  logic          start;
  logic          scrolling;
  logic [LW-1:0] len;
  logic [31:0]   word;

  modport master (
    output clear, wr_en, wr_char, start,
    input  wr_ready, scrolling, len, word
  );

  modport slave (
    input  clear, wr_en, wr_char, start,
    output wr_ready, scrolling, len, word
  );
endinterface

// File: rtl/text_scroller_step_tick.sv
// Free-running step counter with synchronous clear; tick is high for one
// cycle out of every CYCLES while sclr is low.
module step_tick #(
  parameter int CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sclr,
  output logic tick
);
  localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_s;

  assign tick_s = (cnt_r == LAST) && !sclr;
  assign tick   = tick_s;

  // Counter register: restarts on clear or terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (sclr || tick_s) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end
endmodule

// File: rtl/text_scroller.sv
// Message buffer plus 4-character scrolling window feeding the seven-segment
// display driver; the window wraps through a 4-space gap after the text.
module text_scroller
  import text_scroller_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 25000000
) (
  input logic            clk,
  input logic            reset,
  text_scroller_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state_r, state_s;
  logic [LW-1:0] len_r, len_s;
  logic [15:0]   pos_r, pos_s;
  logic [31:0]   word_r, word_s;
  logic [7:0]    mem_r [0:DEPTH-1];

  logic          wr_ready_s;
  logic          wr_fire_s;
  logic          tick_s;
  logic [15:0]   idx_s [0:3];
  logic [7:0]    ch_s  [0:3];

  assign wr_ready_s = (state_r == ST_EDIT) && (len_r < LW'(DEPTH));
  assign wr_fire_s  = bus.wr_en && wr_ready_s && !bus.clear;

  step_tick #(.CYCLES(STEP_CYCLES)) u_step (
    .clk   (clk),
    .reset (reset),
    .sclr  (state_r != ST_SCROLL),
    .tick  (tick_s)
  );

  // Next-state logic: clear beats write, write lands before start is judged.
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    pos_s   = pos_r;
    if (bus.clear) begin
      state_s = ST_EDIT;
      len_s   = {LW{1'b0}};
      pos_s   = 16'd0;
    end else begin
      case (state_r)
        ST_EDIT: begin
          pos_s = 16'd0;
          if (wr_fire_s) begin
            len_s = len_r + LW'(1);
          end else begin
            len_s = len_r;
          end
          if (bus.start && (len_s != {LW{1'b0}})) begin
            state_s = ST_SCROLL;
          end else begin
            state_s = ST_EDIT;
          end
        end
        ST_SCROLL: begin
          if (tick_s) begin
            if ((pos_r + 16'd1) == (16'(len_r) + 16'd4)) begin
              pos_s = 16'd0;
            end else begin
              pos_s = pos_r + 16'd1;
            end
          end else begin
            pos_s = pos_r;
          end
        end
        default: begin
          state_s = ST_EDIT;
          len_s   = {LW{1'b0}};
          pos_s   = 16'd0;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EDIT;
      len_r   <= {LW{1'b0}};
      pos_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      pos_r   <= pos_s;
    end
  end

  // Message RAM: contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_fire_s && !reset) begin
      mem_r[len_r[AW-1:0]] <= bus.wr_char;
    end
  end

  // Window lookup: four read ports, positions past len read as space.
  always_comb begin
    word_s = BLANK_WORD;
    for (int k = 0; k < 4; k++) begin
      idx_s[k] = wrap_index(pos_r + 16'(k), 16'(len_r) + 16'd4);
      if (idx_s[k] < 16'(len_r)) begin
        ch_s[k] = mem_r[idx_s[k][AW-1:0]];
      end else begin
        ch_s[k] = ASCII_SPACE;
      end
      word_s[31-8*k -: 8] = ch_s[k];
    end
  end

  // Display word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r <= BLANK_WORD;
    end else begin
      word_r <= word_s;
    end
  end

  assign bus.wr_ready  = wr_ready_s;
  assign bus.scrolling = (state_r == ST_SCROLL);
  assign bus.len       = len_r;
  assign bus.word      = word_r;
endmodule

// File: tb/tb_text_scroller.sv
// Bench for text_scroller: directed table, hand-written corner sequences and
// randomized traffic, all compared against a message-level reference model.
module tb_text_scroller;
  localparam int DEPTH = 8;
  localparam int STEP  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_scroller_if #(.DEPTH(DEPTH)) bus ();

  text_scroller #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: message as a byte array, window position, cycles in step.
  logic [7:0]  m_msg [DEPTH];
  int          m_len, m_pos, m_cnt;
  bit          m_scr;
  logic [31:0] m_word;

  typedef struct {
    logic        clr;
    logic        we;
    logic [7:0]  ch;
    logic        st;
    int          e_len;
    logic        e_scr;
    logic        e_rdy;
    logic [31:0] e_word;
  } vec_t;
  vec_t vt [12];

  logic [31:0] hello_seq [9];

  function automatic logic [31:0] m_window();
    logic [31:0] w;
    int i;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      i = (m_pos + k) % (m_len + 4);
      w = {w[23:0], (i < m_len) ? m_msg[i] : 8'h20};
    end
    return w;
  endfunction

  task automatic model_edge();
    logic [31:0] nw;
    if (reset) begin
      m_len = 0; m_pos = 0; m_cnt = 0; m_scr = 1'b0; m_word = 32'h20202020;
    end else begin
      nw = m_window();
      if (bus.clear) begin
        m_len = 0; m_pos = 0; m_cnt = 0; m_scr = 1'b0;
      end else if (!m_scr) begin
        if (bus.wr_en && m_len < DEPTH) begin
          m_msg[m_len] = bus.wr_char;
          m_len++;
        end
        if (bus.start && m_len > 0) begin
          m_scr = 1'b1; m_pos = 0; m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == STEP) begin
          m_cnt = 0;
          m_pos = (m_pos + 1) % (m_len + 4);
        end
      end
      m_word = nw;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_word", bus.word, m_word);
    check("model_len", 32'(bus.len), 32'(m_len));
    check("model_scrolling", 32'(bus.scrolling), 32'(m_scr));
    check("model_wr_ready", 32'(bus.wr_ready), 32'(!m_scr && m_len < DEPTH));
  endtask

  task automatic drive(input logic c, input logic w, input logic [7:0] ch, input logic s);
    bus.clear = c; bus.wr_en = w; bus.wr_char = ch; bus.start = s;
  endtask

  task automatic write_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      drive(1'b0, 1'b1, s[i], 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic scroll_hello_to_pos3();
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    write_str("hello");
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 13; k++) step();
    check("pos3_word", bus.word, 32'h6c6f2020);
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 8'h61, 1'b0, 1, 1'b0, 1'b1, 32'h20202020};
    vt[1]  = '{1'b0, 1'b1, 8'h62, 1'b0, 2, 1'b0, 1'b1, 32'h61202020};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b1, 32'h61622020};
    vt[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 32'h61622020};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 32'h20202020};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 32'h20202020};
    vt[6]  = '{1'b0, 1'b1, 8'h6b, 1'b1, 1, 1'b1, 1'b0, 32'h20202020};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b0, 32'h6b202020};
    vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 32'h6b202020};
    vt[9]  = '{1'b0, 1'b1, 8'h7a, 1'b0, 1, 1'b0, 1'b1, 32'h20202020};
    vt[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 32'h7a202020};
    vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 32'h20202020};

    hello_seq = '{32'h68656c6c, 32'h656c6c6f, 32'h6c6c6f20, 32'h6c6f2020, 32'h6f202020,
                  32'h20202020, 32'h20202068, 32'h20206865, 32'h2068656c};

    // Reset and idle.
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step(); step();
    reset = 1'b0;
    check("reset_word", bus.word, 32'h20202020);
    check("reset_len", 32'(bus.len), 32'd0);
    for (int k = 0; k < 10; k++) step();

    // Directed table: short writes, start/clear interactions.
    for (int v = 0; v < 12; v++) begin
      drive(vt[v].clr, vt[v].we, vt[v].ch, vt[v].st);
      step();
      check($sformatf("vec%0d_word", v), bus.word, vt[v].e_word);
      check($sformatf("vec%0d_len", v), 32'(bus.len), 32'(vt[v].e_len));
      check($sformatf("vec%0d_scrolling", v), 32'(bus.scrolling), 32'(vt[v].e_scr));
      check($sformatf("vec%0d_wr_ready", v), 32'(bus.wr_ready), 32'(vt[v].e_rdy));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // "hello" scroll through the gap and wrap.
    write_str("hello");
    step();
    check("hello_edit_word", bus.word, 32'h68656c6c);
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("hello_start_word", bus.word, 32'h68656c6c);
    check("hello_scrolling", 32'(bus.scrolling), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      step();
      if ((k - 1) % 4 == 0)
        check($sformatf("hello_step%0d", (k - 1) / 4), bus.word, hello_seq[((k - 1) / 4) % 9]);
    end

    // Overflow, then writes during scroll.
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    write_str("abcdefgh");
    check("full_len", 32'(bus.len), 32'd8);
    check("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    write_str("x");
    check("overflow_len", 32'(bus.len), 32'd8);
    step();
    check("full_word", bus.word, 32'h61626364);
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 8'h5a, 1'b0); step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("scroll_write_len", 32'(bus.len), 32'd8);
    for (int k = 0; k < 60; k++) step();

    // Clear mid-scroll.
    scroll_hello_to_pos3();
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("clr_mid_len", 32'(bus.len), 32'd0);
    check("clr_mid_scrolling", 32'(bus.scrolling), 32'd0);
    step();
    check("clr_mid_word", bus.word, 32'h20202020);

    // Reset mid-scroll.
    scroll_hello_to_pos3();
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid_len", 32'(bus.len), 32'd0);
    check("rst_mid_scrolling", 32'(bus.scrolling), 32'd0);
    step();
    check("rst_mid_word", bus.word, 32'h20202020);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 40,
            8'($urandom_range(33, 126)), $urandom_range(0, 99) < 8);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
